// File: rtl/inst_align_queue_pkg.sv
// Shared types and helpers for the fetch aligner and instruction queue.
package inst_align_queue_pkg;

  localparam int unsigned INST_Q_DEPTH = 8;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned HALF_W       = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } align_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    logic            is_c;
  } inst_rec_t;

  // A halfword starts a compressed instruction unless its low two bits are 2'b11.
  function automatic logic c_half(input logic [HALF_W-1:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/inst_splitter.sv
// Combinational splitter: turns one fetch word plus any held lower half
// into up to two whole instructions and the next aligner state.
module inst_splitter
  import inst_align_queue_pkg::*;
(
  input  align_state_e      state,
  input  logic [HALF_W-1:0] hold_half,
  input  logic [XLEN-1:0]   hold_addr,
  input  logic [XLEN-1:0]   fetch_addr,
  input  logic [XLEN-1:0]   fetch_data,
  output inst_rec_t         rec0_c,
  output inst_rec_t         rec1_c,
  output logic              rec0_valid_c,
  output logic              rec1_valid_c,
  output align_state_e      next_state_c,
  output logic [HALF_W-1:0] next_hold_half_c,
  output logic [XLEN-1:0]   next_hold_addr_c
);

  logic [HALF_W-1:0] lo_half;
  logic [HALF_W-1:0] hi_half;
  logic [XLEN-1:0]   hi_addr;
  logic              contig;
  logic              hi_push;
  logic              use_hi;
  inst_rec_t         hi_rec;

  always_comb begin
    lo_half          = fetch_data[15:0];
    hi_half          = fetch_data[31:16];
    hi_addr          = {fetch_addr[31:2], 2'b10};
    contig           = (state == ST_HOLD) && (fetch_addr == hold_addr + 32'd2);
    hi_push          = c_half(hi_half);
    hi_rec           = '{inst: {16'h0000, hi_half}, addr: hi_addr, is_c: 1'b1};
    use_hi           = 1'b0;
    rec0_c           = '0;
    rec1_c           = '0;
    rec0_valid_c     = 1'b0;
    rec1_valid_c     = 1'b0;
    next_state_c     = ST_IDLE;
    next_hold_half_c = hold_half;
    next_hold_addr_c = hold_addr;

    if (contig) begin
      // Complete the straddling instruction, then treat the upper half normally.
      rec0_c       = '{inst: {lo_half, hold_half}, addr: hold_addr, is_c: 1'b0};
      rec0_valid_c = 1'b1;
      rec1_c       = hi_rec;
      rec1_valid_c = hi_push;
      use_hi       = 1'b1;
    end else if (!fetch_addr[1]) begin
      if (c_half(lo_half)) begin
        rec0_c       = '{inst: {16'h0000, lo_half}, addr: fetch_addr, is_c: 1'b1};
        rec0_valid_c = 1'b1;
        rec1_c       = hi_rec;
        rec1_valid_c = hi_push;
        use_hi       = 1'b1;
      end else begin
        rec0_c       = '{inst: fetch_data, addr: fetch_addr, is_c: 1'b0};
        rec0_valid_c = 1'b1;
      end
    end else begin
      rec0_c       = hi_rec;
      rec0_valid_c = hi_push;
      use_hi       = 1'b1;
    end

    if (use_hi && !hi_push) begin
      next_state_c     = ST_HOLD;
      next_hold_half_c = hi_half;
      next_hold_addr_c = hi_addr;
    end
  end

endmodule

// File: rtl/inst_align_queue.sv
// Fetch-side aligner feeding a first-word-fall-through instruction queue.
// Head outputs are registered and preloaded with the next head every cycle.
module inst_align_queue
  import inst_align_queue_pkg::*;
#(
  parameter int unsigned DEPTH = INST_Q_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_addr,
  input  logic [31:0]      fetch_data,
  output logic             fetch_ready,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic             out_is_c,
  input  logic             out_pop,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  align_state_e      state_q, state_d;
  logic [HALF_W-1:0] hold_half_q, hold_half_d;
  logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0]  count_d, left_after_pop, n_push;
  inst_rec_t         head_q, head_d;
  logic              valid_d, ready_d;
  logic              accept, pop, push0, push1;

  inst_rec_t         mem [DEPTH];

  inst_rec_t         rec0, rec1;
  logic              rec0_valid, rec1_valid;
  align_state_e      sp_state;
  logic [HALF_W-1:0] sp_hold_half;
  logic [XLEN-1:0]   sp_hold_addr;

  inst_splitter u_splitter (
    .state            (state_q),
    .hold_half        (hold_half_q),
    .hold_addr        (hold_addr_q),
    .fetch_addr       (fetch_addr),
    .fetch_data       (fetch_data),
    .rec0_c           (rec0),
    .rec1_c           (rec1),
    .rec0_valid_c     (rec0_valid),
    .rec1_valid_c     (rec1_valid),
    .next_state_c     (sp_state),
    .next_hold_half_c (sp_hold_half),
    .next_hold_addr_c (sp_hold_addr)
  );

  assign out_inst = head_q.inst;
  assign out_addr = head_q.addr;
  assign out_is_c = head_q.is_c;

  // Next-state logic: freeze when not ready, flush beats push/pop.
  always_comb begin
    accept         = fetch_valid && fetch_ready && rdy_in && !flush;
    pop            = out_pop && out_valid && rdy_in && !flush;
    push0          = accept && rec0_valid;
    push1          = accept && rec1_valid;
    n_push         = CNT_W'(push0) + CNT_W'(push1);
    rd_next        = rd_ptr_q + PTR_W'(pop);
    left_after_pop = count - CNT_W'(pop);
    state_d        = state_q;
    hold_half_d    = hold_half_q;
    hold_addr_d    = hold_addr_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count;
    head_d         = head_q;
    valid_d        = out_valid;
    ready_d        = fetch_ready;

    if (rdy_in) begin
      if (flush) begin
        state_d  = ST_IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        head_d   = '0;
        valid_d  = 1'b0;
        ready_d  = 1'b1;
      end else begin
        if (accept) begin
          state_d     = sp_state;
          hold_half_d = sp_hold_half;
          hold_addr_d = sp_hold_addr;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = rd_next;
        count_d  = count + n_push - CNT_W'(pop);
        valid_d  = count_d != '0;
        ready_d  = (CNT_W'(DEPTH) - count_d) >= CNT_W'(2);
        // An empty-after-pop queue takes its new head straight from this cycle's push.
        if (count_d == '0) begin
          head_d = '0;
        end else if (left_after_pop == '0) begin
          head_d = rec0;
        end else begin
          head_d = mem[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      hold_half_q <= '0;
      hold_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count       <= '0;
      head_q      <= '0;
      out_valid   <= 1'b0;
      fetch_ready <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_half_q <= hold_half_d;
      hold_addr_q <= hold_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count       <= count_d;
      head_q      <= head_d;
      out_valid   <= valid_d;
      fetch_ready <= ready_d;
    end
  end

  // Queue storage; no reset needed since pointers gate every read.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push0) begin
      mem[wr_ptr_q] <= rec0;
    end
    if (!rst_in && push1) begin
      mem[wr_ptr_q + PTR_W'(1)] <= rec1;
    end
  end

endmodule
